// File: rtl/irq_pkg.sv
// irq_pkg: shared sizes and FSM state type for the interrupt capture stage
package irq_pkg;
    localparam int NUM_IRQ = 8;
    localparam int ID_W = $clog2(NUM_IRQ);
    typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t;
endpackage

// File: rtl/irq_pend_capture_if.sv
// irq_pend_capture_if: request, snapshot handshake and lost-flag signals
interface irq_pend_capture_if;
    import irq_pkg::*;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pend_out;
    logic irq_valid;
    logic ack;
    logic [ID_W-1:0] ack_id;
    logic ack_err;
    logic [NUM_IRQ-1:0] lost;
    logic lost_clr;
    modport master (output irq_in, mask, ack, ack_id, lost_clr, input pend_out, irq_valid, ack_err, lost);
    modport slave (input irq_in, mask, ack, ack_id, lost_clr, output pend_out, irq_valid, ack_err, lost);
endinterface

// File: rtl/irq_sync.sv
// irq_sync: 8-bit two-flop synchronizer for asynchronous request lines
module irq_sync
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic [NUM_IRQ-1:0] d,
    output logic [NUM_IRQ-1:0] q
);
    logic [NUM_IRQ-1:0] meta;
    always_ff @(posedge clk) begin
        meta <= rst ? '0 : d;
        q <= rst ? '0 : meta;
    end
endmodule

// File: rtl/irq_pend_capture.sv
// irq_pend_capture: sticky pending capture, masked snapshot and ack handshake
// Define IRQ_SYNC_IN_EN to pass irq_in through a 2-flop synchronizer first.
module irq_pend_capture
    import irq_pkg::*;
(
    input logic clk,
    input logic rst,
    irq_pend_capture_if.slave bus
);
    irq_state_t state, state_n;
    logic [NUM_IRQ-1:0] irq_s, prev, edge_v, pend, lost, snap, clr;
    logic err, acc, hit;
`ifdef IRQ_SYNC_IN_EN
    irq_sync u_sync (.clk(clk), .rst(rst), .d(bus.irq_in), .q(irq_s));
`else
    assign irq_s = bus.irq_in;
`endif
    assign edge_v = irq_s & ~prev;
    assign acc = (state == REQ) && bus.ack;
    assign hit = snap[bus.ack_id];
    assign clr = (acc && hit) ? NUM_IRQ'(1) << bus.ack_id : '0;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (|(pend & bus.mask) ? REQ : IDLE) :
                  state == REQ  ? (bus.ack ? GAP : REQ) : IDLE;
    end
    // A same-cycle edge re-sets a bit being cleared and is not counted as lost
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prev <= '0;
            pend <= '0;
            lost <= '0;
            snap <= '0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            prev <= irq_s;
            pend <= (pend & ~clr) | edge_v;
            lost <= bus.lost_clr ? '0 : lost | (edge_v & pend & ~clr);
            snap <= (state == IDLE && state_n == REQ) ? pend & bus.mask : snap;
            err <= acc && !hit;
        end
    end
    assign bus.pend_out = snap;
    assign bus.irq_valid = state == REQ;
    assign bus.ack_err = err;
    assign bus.lost = lost;
endmodule

// File: tb/tb_irq_pend_capture.sv
// tb_irq_pend_capture: directed scenario tests for irq_pend_capture
module tb_irq_pend_capture;
    logic clk = 0;
    logic rst = 1;
    int pass = 0;
    int total = 0;
    irq_pend_capture_if bus ();
    irq_pend_capture dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_and_settle(input logic [2:0] id);
        bus.ack = 1; bus.ack_id = id;
        step();
        bus.ack = 0;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1;
        step(2);
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.irq_valid); else pass++;
        total++; if (bus.pend_out !== 8'h00) $display("FAIL reset_pend_out got=%h exp=00", bus.pend_out); else pass++;
        total++; if (bus.ack_err !== 1'b0) $display("FAIL reset_ack_err got=%b exp=0", bus.ack_err); else pass++;
        total++; if (bus.lost !== 8'h00) $display("FAIL reset_lost got=%h exp=00", bus.lost); else pass++;
        rst = 0;
        step();
    endtask

    task automatic test_basic();
        bus.irq_in = 8'h24;
        step();
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL basic_early got=%b exp=0", bus.irq_valid); else pass++;
        step();
        total++; if (bus.irq_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", bus.irq_valid); else pass++;
        total++; if (bus.pend_out !== 8'h24) $display("FAIL basic_snap got=%h exp=24", bus.pend_out); else pass++;
        bus.irq_in = 8'h00;
        step();
        total++; if (bus.pend_out !== 8'h24) $display("FAIL basic_frozen got=%h exp=24", bus.pend_out); else pass++;
        bus.ack = 1; bus.ack_id = 3'd5;
        step();
        bus.ack = 0;
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL basic_gap got=%b exp=0", bus.irq_valid); else pass++;
        total++; if (bus.ack_err !== 1'b0) $display("FAIL basic_no_err got=%b exp=0", bus.ack_err); else pass++;
        step();
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL basic_idle got=%b exp=0", bus.irq_valid); else pass++;
        step();
        total++; if (bus.irq_valid !== 1'b1) $display("FAIL basic_rereq got=%b exp=1", bus.irq_valid); else pass++;
        total++; if (bus.pend_out !== 8'h04) $display("FAIL basic_resnap got=%h exp=04", bus.pend_out); else pass++;
        ack_and_settle(3'd2);
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL basic_drained got=%b exp=0", bus.irq_valid); else pass++;
    endtask

    task automatic test_mask();
        bus.mask = 8'h0F; bus.irq_in = 8'h80;
        step(3);
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL mask_hidden got=%b exp=0", bus.irq_valid); else pass++;
        bus.mask = 8'hFF; bus.irq_in = 8'h00;
        step();
        total++; if (bus.irq_valid !== 1'b1) $display("FAIL mask_valid got=%b exp=1", bus.irq_valid); else pass++;
        total++; if (bus.pend_out !== 8'h80) $display("FAIL mask_snap got=%h exp=80", bus.pend_out); else pass++;
        ack_and_settle(3'd7);
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL mask_drained got=%b exp=0", bus.irq_valid); else pass++;
    endtask

    task automatic test_ack_err();
        bus.irq_in = 8'h01;
        step(2);
        bus.irq_in = 8'h00;
        total++; if (bus.pend_out !== 8'h01) $display("FAIL err_snap got=%h exp=01", bus.pend_out); else pass++;
        bus.ack = 1; bus.ack_id = 3'd3;
        step();
        bus.ack = 0;
        total++; if (bus.ack_err !== 1'b1) $display("FAIL err_pulse got=%b exp=1", bus.ack_err); else pass++;
        step();
        total++; if (bus.ack_err !== 1'b0) $display("FAIL err_one_cycle got=%b exp=0", bus.ack_err); else pass++;
        step();
        total++; if (bus.irq_valid !== 1'b1) $display("FAIL err_rereq got=%b exp=1", bus.irq_valid); else pass++;
        total++; if (bus.pend_out !== 8'h01) $display("FAIL err_resnap got=%h exp=01", bus.pend_out); else pass++;
        ack_and_settle(3'd0);
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL err_drained got=%b exp=0", bus.irq_valid); else pass++;
    endtask

    task automatic test_lost();
        bus.irq_in = 8'h04;
        step();
        bus.irq_in = 8'h00;
        step();
        total++; if (bus.lost !== 8'h00) $display("FAIL lost_first got=%h exp=00", bus.lost); else pass++;
        bus.irq_in = 8'h04;
        step();
        bus.irq_in = 8'h00;
        total++; if (bus.lost !== 8'h04) $display("FAIL lost_set got=%h exp=04", bus.lost); else pass++;
        bus.lost_clr = 1;
        step();
        bus.lost_clr = 0;
        total++; if (bus.lost !== 8'h00) $display("FAIL lost_clr got=%h exp=00", bus.lost); else pass++;
        ack_and_settle(3'd2);
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL lost_drained got=%b exp=0", bus.irq_valid); else pass++;
    endtask

    task automatic test_set_wins();
        bus.irq_in = 8'h02;
        step(2);
        bus.irq_in = 8'h00;
        step();
        total++; if (bus.pend_out !== 8'h02) $display("FAIL race_snap got=%h exp=02", bus.pend_out); else pass++;
        bus.ack = 1; bus.ack_id = 3'd1; bus.irq_in = 8'h02;
        step();
        bus.ack = 0; bus.irq_in = 8'h00;
        total++; if (bus.lost !== 8'h00) $display("FAIL race_lost got=%h exp=00", bus.lost); else pass++;
        step(2);
        total++; if (bus.irq_valid !== 1'b1) $display("FAIL race_rereq got=%b exp=1", bus.irq_valid); else pass++;
        total++; if (bus.pend_out !== 8'h02) $display("FAIL race_resnap got=%h exp=02", bus.pend_out); else pass++;
        ack_and_settle(3'd1);
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL race_drained got=%b exp=0", bus.irq_valid); else pass++;
    endtask

    task automatic test_mid_reset();
        bus.irq_in = 8'h08;
        step();
        bus.irq_in = 8'h00;
        step();
        bus.irq_in = 8'h08;
        step();
        total++; if (bus.irq_valid !== 1'b1) $display("FAIL rst_pre_valid got=%b exp=1", bus.irq_valid); else pass++;
        total++; if (bus.lost !== 8'h08) $display("FAIL rst_pre_lost got=%h exp=08", bus.lost); else pass++;
        rst = 1; bus.ack = 1; bus.ack_id = 3'd3; bus.irq_in = 8'h00;
        step();
        rst = 0; bus.ack = 0;
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus.irq_valid); else pass++;
        total++; if (bus.pend_out !== 8'h00) $display("FAIL rst_pend_out got=%h exp=00", bus.pend_out); else pass++;
        total++; if (bus.lost !== 8'h00) $display("FAIL rst_lost got=%h exp=00", bus.lost); else pass++;
        total++; if (bus.ack_err !== 1'b0) $display("FAIL rst_ack_err got=%b exp=0", bus.ack_err); else pass++;
        step(3);
        total++; if (bus.irq_valid !== 1'b0) $display("FAIL rst_no_stale got=%b exp=0", bus.irq_valid); else pass++;
    endtask

    initial begin
        bus.irq_in = 8'h00; bus.mask = 8'hFF; bus.ack = 0; bus.ack_id = 3'd0; bus.lost_clr = 0;
        test_reset();
        test_basic();
        test_mask();
        test_ack_err();
        test_lost();
        test_set_wins();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/irq_pend_capture.md
# irq_pend_capture

Interrupt request capture stage that sits directly upstream of the 8-input priority encoder. It converts raw request lines into sticky pending bits and applies an enable mask. It presents a frozen snapshot vector to the encoder, then waits for a valid/ack handshake that returns the encoded index and clears the serviced bit. It also flags requests lost while their bit was already pending.

## Interface
- NUM_IRQ, 8, number of request lines; only 8 is supported.
- ID_W, 3, index width, equal to $clog2(NUM_IRQ).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  8  raw request lines; a rising edge requests service.
- mask  in  8  1 = line enabled for presentation.
- pend_out  out  8  snapshot of masked pending bits fed to the encoder; stable while irq_valid = 1.
- irq_valid  out  1  snapshot valid, non-zero.
- ack  in  1  downstream has consumed the snapshot; sampled only while irq_valid = 1.
- ack_id  in  3  encoded index of the bit being serviced; qualified by ack.
- ack_err  out  1  one-cycle pulse: ack_id named a bit not set in the snapshot.
- lost  out  8  sticky; a new edge arrived while the bit was already pending.
- lost_clr  in  1  clears all lost bits.

## Operation
- Edge detect: edge[i] = irq_in[i] & ~prev[i]. prev is registered and resets to 0, so a line held high through reset release produces one edge.
- Pending register pend[7:0]:
  - set on edge, regardless of mask;
  - cleared only by an accepted ack for that index;
  - if an edge and a clear of the same bit occur in the same cycle, the set wins: the bit stays pending and lost is not set.
- lost[i] is set when edge[i] arrives and pend[i] is already 1. lost_clr takes priority over a same-cycle set.
- FSM states:
  - IDLE: irq_valid = 0. If (pend & mask) != 0, load pend_out <= pend & mask and go to REQ.
  - REQ: irq_valid = 1; pend_out is frozen, so new edges and mask changes do not alter it. On ack:
    - if pend_out[ack_id] = 1, clear pend[ack_id];
    - otherwise pulse ack_err and clear nothing;
    - in both cases go to GAP.
  - GAP: irq_valid = 0 for exactly one cycle, then IDLE.
- In IDLE and GAP, pend_out holds its last value. Downstream must qualify it with irq_valid.
- A bit masked while pending stays pending. It is presented on the first IDLE evaluation after it is unmasked.
- rst mid-handshake: FSM returns to IDLE; pend, lost, prev, pend_out, irq_valid and ack_err all go to 0. Any in-flight ack is discarded.

## Timing
- Reset values: pend_out = 0, irq_valid = 0, ack_err = 0, lost = 0.
- Latency without sync, from a rising edge sampled at clock edge N:
  - pend set after N;
  - FSM enters REQ after N+1;
  - irq_valid = 1 in the cycle following clock edge N+1.
- ack accepted on the clock edge where irq_valid = 1 and ack = 1:
  - irq_valid is 0 from that edge for one GAP cycle;
  - the earliest next REQ is 2 cycles after the ack edge.
- ack_err is high for exactly the cycle after the accepting edge.
- Back-to-back service rate: one index per 3 cycles (REQ, GAP, IDLE).

## Configuration
- IRQ_SYNC_IN_EN defined: irq_in passes through a 2-flop synchronizer (reset to 0) before edge detection. Input-to-irq_valid latency grows by 2 cycles; lines may be asynchronous.
- IRQ_SYNC_IN_EN undefined: irq_in must be synchronous to clk and is used directly. Latency is as in Timing.

## Structure
- Package irq_pkg: NUM_IRQ, ID_W, and the state enum irq_state_t {IDLE, REQ, GAP}.
- Sub-module irq_sync: an 8-bit 2-flop synchronizer, instantiated only under IRQ_SYNC_IN_EN.
- Everything else lives in irq_pend_capture.

## Test plan
- Reset, then irq_in = 8'h00 -> 8'h24 with mask = 8'hFF -> irq_valid = 1 two cycles later, pend_out = 8'h24. Ack with ack_id = 5 -> pend = 8'h04; after GAP and IDLE, pend_out = 8'h04 and irq_valid = 1 again.
- mask = 8'h0F, edge on bit 7 -> pend[7] = 1, irq_valid stays 0. Set mask = 8'hFF -> pend_out = 8'h80 presented.
- In REQ with pend_out = 8'h01, ack with ack_id = 3 -> ack_err pulses 1 cycle, pend unchanged. Next snapshot is still 8'h01.
- Bit 2 pending, second rising edge on bit 2 -> lost = 8'h04. Pulse lost_clr -> lost = 8'h00.
- Ack for bit 1 in the same cycle as a new edge on bit 1 -> pend[1] stays 1, lost[1] stays 0.
- Assert rst while irq_valid = 1 -> all outputs 0 the next cycle; bits pending before reset are not presented.
